// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush arbiter with stall watchdog.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int          FLUSH_LEN   = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter int          STALL_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam int HW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t        state, state_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic [31:0]   pc_q, pc_next;
  logic [SW-1:0] streak;
  logic          timeout_q;
  logic          exc;
  logic [31:0]   target;
  logic [5:0]    stall_raw;
  logic          flush_raw;
  logic [31:0]   new_pc_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      hold_cnt <= '0;
      pc_q     <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      pc_q     <= pc_next;
    end
  end

  always_comb begin
    exc        = |excepttype;
    target     = (excepttype == 32'h0000_000e) ? cp0_epc : EXC_VECTOR;
    state_next = state;
    hold_next  = hold_cnt;
    pc_next    = pc_q;
    stall_raw  = '0;
    flush_raw  = 1'b0;
    new_pc_raw = pc_q;
    case (state)
      FLUSH: begin
        // Flush tail: requests and new exceptions are ignored until the count expires.
        flush_raw = 1'b1;
        hold_next = hold_cnt - HW'(1);
        if (hold_cnt <= HW'(1))
          state_next = RUN;
      end
      default: begin
        if (exc) begin
          flush_raw  = 1'b1;
          new_pc_raw = target;
          pc_next    = target;
          if (FLUSH_LEN > 1) begin
            state_next = FLUSH;
            hold_next  = HW'(FLUSH_LEN - 1);
          end else begin
            state_next = RUN;
          end
        end else begin
          if (stallreq_mem)
            stall_raw = 6'b011111;
          else if (stallreq_ex)
            stall_raw = 6'b001111;
          else if (stallreq_id)
            stall_raw = 6'b000111;
          state_next = (stall_raw != '0) ? STALL : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak    <= '0;
      timeout_q <= 1'b0;
    end else if (stall_raw != '0) begin
      if (streak != SW'(STALL_LIMIT))
        streak <= streak + SW'(1);
      if (streak >= SW'(STALL_LIMIT - 1))
        timeout_q <= 1'b1;
    end else begin
      streak <= '0;
    end
  end

  // Outputs are forced to their reset values combinationally while rst is high.
  assign stall         = rst ? 6'b0  : stall_raw;
  assign flush         = rst ? 1'b0  : flush_raw;
  assign new_pc        = rst ? 32'b0 : new_pc_raw;
  assign stall_timeout = timeout_q & ~rst;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] pstall_q, pflush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pstall_q <= '0;
      pflush_q <= '0;
    end else begin
      if (stall_raw != '0 && pstall_q != 32'hFFFF_FFFF)
        pstall_q <= pstall_q + 32'd1;
      if (state != FLUSH && exc && pflush_q != 32'hFFFF_FFFF)
        pflush_q <= pflush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = rst ? 32'b0 : pstall_q;
  assign perf_flush_cnt = rst ? 32'b0 : pflush_q;
`else
  assign perf_stall_cnt = 32'b0;
  assign perf_flush_cnt = 32'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic [31:0] excepttype = 32'h0;
  logic [31:0] cp0_epc = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  int errors = 0;
  int checks = 0;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [31:0] EXP_PSTALL = 32'd10;
  localparam logic [31:0] EXP_PFLUSH = 32'd3;
`else
  localparam logic [31:0] EXP_PSTALL = 32'd0;
  localparam logic [31:0] EXP_PFLUSH = 32'd0;
`endif

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        chk_pc;
    logic        timeout;
    string       tag;
  } exp_t;

  exp_t sb[$];

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .stallreq_mem   (stallreq_mem),
    .excepttype     (excepttype),
    .cp0_epc        (cp0_epc),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .stall_timeout  (stall_timeout),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs after the edge, push expectation, compare mid-cycle.
  task automatic cyc(input logic r, input logic id, input logic ex, input logic mem,
                     input logic [31:0] et, input logic [31:0] epc,
                     input logic [5:0] es, input logic ef, input logic [31:0] ep,
                     input logic eto, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    excepttype = et; cp0_epc = epc;
    sb.push_back('{stall: es, flush: ef, pc: ep, chk_pc: (ef | r), timeout: eto, tag: tag});
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".stall"}, {26'b0, stall}, {26'b0, e.stall});
    chk({e.tag, ".flush"}, {31'b0, flush}, {31'b0, e.flush});
    chk({e.tag, ".timeout"}, {31'b0, stall_timeout}, {31'b0, e.timeout});
    if (e.chk_pc)
      chk({e.tag, ".new_pc"}, new_pc, e.pc);
  endtask

  initial begin
    // Reset held against competing requests and an exception
    cyc(1, 0, 0, 1, 32'h8, 0, 6'b0, 0, 32'h0, 0, "reset0");
    cyc(1, 0, 0, 1, 32'h8, 0, 6'b0, 0, 32'h0, 0, "reset1");
    chk("reset.perf_stall", perf_stall_cnt, 32'h0);
    chk("reset.perf_flush", perf_flush_cnt, 32'h0);

    // Priority
    cyc(0, 1, 1, 0, 0, 0, 6'b001111, 0, 0, 0, "prio_id_ex");
    cyc(0, 1, 1, 1, 0, 0, 6'b011111, 0, 0, 0, "prio_all");
    cyc(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, "prio_drop");

    // Exception beats a stall request; second flush cycle ignores requests and a new code
    cyc(0, 0, 0, 1, 32'h8, 0, 6'b0, 1, 32'h20, 0, "exc_c1");
    cyc(0, 1, 0, 0, 32'he, 32'h9999, 6'b0, 1, 32'h20, 0, "exc_c2");
    cyc(0, 1, 0, 0, 0, 0, 6'b000111, 0, 0, 0, "exc_c3");
    cyc(0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 0, "exc_idle");

    // ERET
    cyc(0, 0, 0, 0, 32'he, 32'h1234, 6'b0, 1, 32'h1234, 0, "eret_c1");
    cyc(0, 0, 0, 0, 0, 32'h5678, 6'b0, 1, 32'h1234, 0, "eret_c2");
    cyc(0, 0, 0, 0, 0, 32'h5678, 6'b0, 0, 0, 0, "eret_done");

    // Watchdog: 64 stalled cycles, flag rises after the last one and sticks
    for (int i = 0; i < 64; i++)
      cyc(0, 0, 1, 0, 0, 0, 6'b001111, 0, 0, 0, "wd_stall");
    cyc(0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 1, "wd_rise");
    cyc(0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 1, "wd_sticky");

    // rst mid-flush aborts; next cycle is RUN
    cyc(0, 0, 0, 0, 32'h8, 0, 6'b0, 1, 32'h20, 1, "pre_rst_exc");
    cyc(1, 0, 0, 0, 32'h8, 0, 6'b0, 0, 32'h0, 0, "rst_in_flush");
    cyc(0, 1, 0, 0, 0, 0, 6'b000111, 0, 0, 0, "run_after_rst");

    // Perf: 10 stalled cycles (one above) and 3 exceptions
    for (int i = 0; i < 9; i++)
      cyc(0, 0, 0, 1, 0, 0, 6'b011111, 0, 0, 0, "perf_stall");
    cyc(0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 0, "perf_gap");
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 32'h4, 0, 6'b0, 1, 32'h20, 0, "perf_exc_c1");
      cyc(0, 0, 0, 0, 32'h4, 0, 6'b0, 1, 32'h20, 0, "perf_exc_c2");
    end
    cyc(0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 0, "perf_end");
    chk("perf_stall_cnt", perf_stall_cnt, EXP_PSTALL);
    chk("perf_flush_cnt", perf_flush_cnt, EXP_PFLUSH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core. It arbitrates stall requests from the ID, EX and MEM stages and produces the per-stage hold vector consumed by the PC register and by every inter-stage register, including the IF/ID register. It converts committed exceptions into a multi-cycle flush with a redirect PC, and watches for runaway stalls. Optional performance counters are included.

## Interface
Parameters:
- FLUSH_LEN, 2: total cycles `flush` stays high per exception (≥1).
- EXC_VECTOR, 32'h0000_0020: redirect PC for all non-ERET exceptions.
- STALL_LIMIT, 64: consecutive stalled cycles that trip the watchdog (≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stallreq_id  in  1  ID stage needs a hold, e.g. load-use.
- stallreq_ex  in  1  EX stage needs a hold, e.g. multi-cycle div/madd.
- stallreq_mem  in  1  MEM stage waiting on the data bus.
- excepttype  in  32  committed exception code from MEM; 0 means none.
- cp0_epc  in  32  EPC value for ERET.
- stall  out  6  hold vector: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB.
- flush  out  1  clear all pipeline registers.
- new_pc  out  32  redirect target; valid while `flush`=1.
- stall_timeout  out  1  sticky watchdog flag.
- perf_stall_cnt  out  32  stalled-cycle count.
- perf_flush_cnt  out  32  flush event count.

## Operation
- States: RUN, STALL, FLUSH. Encoding is free.
- `stall`, `flush` and `new_pc` are combinational from the inputs and the current state, so pipeline registers sample them at the same edge.
- Priority in RUN and STALL: exception > stallreq_mem > stallreq_ex > stallreq_id.
  - Exception: excepttype≠0 → flush=1, stall=0.
  - stallreq_mem → stall=6'b011111.
  - stallreq_ex → stall=6'b001111.
  - stallreq_id → stall=6'b000111.
  - None of the above → stall=0, flush=0.
- new_pc selection:
  - excepttype==32'h0000_000e (ERET) → new_pc=cp0_epc.
  - Any other nonzero code → new_pc=EXC_VECTOR.
  - new_pc is latched in the first flush cycle and held from the register while in FLUSH.
- Transitions:
  - RUN/STALL with an exception → FLUSH, with the hold counter loaded to FLUSH_LEN-1. If FLUSH_LEN==1, stay in or go to RUN instead.
  - RUN with any stall request → STALL.
  - STALL with no request → RUN.
  - FLUSH: flush=1, stall=0. All stall requests and new exceptions are ignored. The counter decrements each cycle; at 0 → RUN.
- Watchdog:
  - A streak counter increments every cycle with stall≠0 and clears when stall==0.
  - When the streak reaches STALL_LIMIT, stall_timeout is set. It is sticky and only rst clears it.
  - The streak counter saturates at STALL_LIMIT.

## Timing
- Reset values: state=RUN, stall=0, flush=0, new_pc=0, stall_timeout=0, perf counters=0, hold and streak counters=0.
- While rst=1, all outputs are forced to their reset values regardless of the other inputs.
- Zero-cycle latency from request to `stall` or `flush`. The flush pulse width is exactly FLUSH_LEN cycles.
- An exception arriving in the same cycle as any stall request wins: no stall is asserted in that cycle.
- rst asserted mid-FLUSH aborts the flush. The next cycle after rst deasserts is RUN.
- excepttype is sampled only on FLUSH entry. A changed value during FLUSH does not alter new_pc.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - perf_stall_cnt increments each cycle with stall≠0.
  - perf_flush_cnt increments on each FLUSH entry, or on each single-cycle flush when FLUSH_LEN==1.
  - Both counters saturate at 32'hFFFF_FFFF.
- PIPE_CTRL_PERF_EN undefined: both ports remain but are tied to 0, and no counter flops are synthesized.

## Test plan
- Reset: assert rst for 2 cycles while stallreq_mem=1 and excepttype=8 → stall=0, flush=0, new_pc=0, stall_timeout=0.
- Priority: stallreq_id=1 and stallreq_ex=1 together → stall=6'b001111. Then stallreq_mem=1 is added → stall=6'b011111. All requests drop → stall=0 in the same cycle.
- Exception: excepttype=32'h8 together with stallreq_mem=1, FLUSH_LEN=2 → flush=1 for exactly 2 cycles, stall=0 throughout, new_pc=32'h20. A stallreq_id raised in the second cycle is ignored and takes effect in the third cycle.
- ERET: excepttype=32'he with cp0_epc=32'h0000_1234 → new_pc=32'h1234. Changing cp0_epc during FLUSH does not change new_pc.
- Watchdog: hold stallreq_ex=1 for 64 cycles with STALL_LIMIT=64 → stall_timeout rises after the 64th stalled cycle and stays high after the request drops, until rst.
- Performance counters, with PIPE_CTRL_PERF_EN defined: 10 stalled cycles plus 3 exceptions → perf_stall_cnt=10, perf_flush_cnt=3. With the macro undefined, both read 0.
